lcd1602_bus_responder: RTL and testbench
========================================

// Module: lcd1602_bus_responder
// PURPOSE
//  Responder end of the LCD1602 (HD44780-style) 8-bit write bus. Decodes rs/rw/enable/data
//  from the panel controller, executes instructions, and keeps a shadow DDRAM (32 chars) plus
//  cursor and display state. Used as the on-board panel model for simulation, and as the
//  source for mirroring the LCD contents to other outputs.
// PARAMETERS
//  CMD_CYCLES    4   busy hold after any non-clear instruction or data write (>=1)
//  CLEAR_CYCLES  64  busy hold after the clear fill completes (>=1)
// PORTS
//  clk          in   1  system clock, single domain
//  reset        in   1  synchronous, active-high
//  lcd_rs       in   1  0 = instruction, 1 = data
//  lcd_rw       in   1  0 = write; 1 = read, which is unsupported
//  lcd_enable   in   1  strobe; a transaction is taken on its falling edge
//  lcd_data     in   8  bus data
//  rd_addr      in   5  shadow index: 0-15 = line 1, 16-31 = line 2
//  rd_char      out  8  shadow char at rd_addr, registered, 1-cycle latency
//  cg_rd_addr   in   6  CGRAM row address {char[2:0], row[2:0]}
//  cg_rd_data   out  5  CGRAM row bits, registered, 1-cycle latency
//  cursor_addr  out  7  current DDRAM address counter
//  display_on   out  1  display control D bit
//  cursor_on    out  1  display control C bit
//  blink_on     out  1  display control B bit
//  two_line     out  1  function set N bit
//  busy         out  1  high while an accepted transaction executes
//  cmd_strobe   out  1  1-cycle pulse when a transaction finishes executing
//  bad_access   out  1  1-cycle pulse when a transaction is dropped
// BEHAVIOUR
//  Sampling: lcd_enable/rs/rw/data are registered every cycle. fall = en_q & ~lcd_enable.
//   On fall, the rs/rw/data values registered in the previous cycle are captured.
//  FSM states and transitions:
//   IDLE: on fall, busy goes to 1 next cycle and the FSM enters EXEC.
//   EXEC: executes the captured transaction (1 cycle). Clear goes to FILL; everything else
//    goes to HOLD with cnt = CMD_CYCLES-1.
//   FILL: writes 0x20 to index 0..31, one per cycle (32 cycles), then HOLD with
//    cnt = CLEAR_CYCLES-1.
//   HOLD: decrements cnt. At 0: go to IDLE, busy = 0, and cmd_strobe pulses that cycle.
//  Dropped transactions:
//   A fall during EXEC, FILL or HOLD is dropped, with a bad_access pulse; state is unchanged.
//   rw=1 on fall is dropped with a bad_access pulse and no busy.
//  Instruction decode (rs=0) uses the highest set bit:
//   1aaaaaaa: DDRAM mode, addr = a.
//   01aaaaaa: CGRAM mode, cg_addr = a.
//   001xNxxx: two_line = N.
//   0001SRxx: if S=0, the cursor moves right (R=1) or left (R=0) using the wrap rule below.
//    If S=1, the instruction is a no-op.
//   00001DCB: sets display_on, cursor_on and blink_on.
//   000001Ix: id = I. The S bit is ignored.
//   0000001x: addr = 0 and DDRAM mode.
//   00000001: clear. Goes to FILL, then addr = 0, id = 1, DDRAM mode.
//   00000000: no-op.
//  Data write (rs=1):
//   DDRAM mode: addresses 0x00-0x0F map to index 0-15 and 0x40-0x4F map to 16-31. Writes to
//    other addresses are discarded, but the address still steps.
//   CGRAM mode: stores data[4:0] at cg_addr, then cg_addr steps by +/-1 and wraps mod 64.
//  DDRAM address step, per id:
//   Increment: 0x27->0x40 and 0x67->0x00.
//   Decrement: 0x00->0x67 and 0x40->0x27.
//  Timing: for a fall detected at cycle n, the effect is visible at n+2 (after EXEC).
//   A non-clear transaction has busy = 1 for 1 + CMD_CYCLES cycles.
//  Reset: forces FILL, so busy = 1 and the buffer is refilled with spaces. Register values:
//   cursor_addr = 0, id = 1, mode = DDRAM.
//   display_on, cursor_on, blink_on, two_line = 0.
//   cmd_strobe, bad_access, rd_char, cg_rd_data = 0.
//  Reset mid-operation aborts the current transaction and restarts the fill from index 0.
//  Reset does not clear CGRAM.
// CONFIGURATION
//  LCD1602_CGRAM_EN defined: a 64x5 CGRAM is implemented, and cg_rd_data returns the stored rows.
//  LCD1602_CGRAM_EN undefined: there is no storage. CGRAM writes are accepted and cg_addr still
//   steps, but cg_rd_data = 0. Busy and cmd_strobe timing is identical in both builds.
// TESTING
//  1. Reset, then wait 32+CLEAR_CYCLES+2 cycles -> busy=0; rd_char=0x20 for all 32 indices;
//     cursor_addr=0.
//  2. Send 0x84 then 0x46 ('F') -> rd_addr 4 returns 0x46; cursor_addr=0x05; two cmd_strobe pulses.
//  3. Send 0x0C then 0x38 -> display_on=1, cursor_on=0, blink_on=0, two_line=1.
//  4. Send 0x04, 0xC0, then data 0x41 -> rd_addr 16 returns 0x41; cursor_addr=0x27.
//  5. Send a second fall 2 cycles after the first -> bad_access pulses once; the second
//     transaction has no effect.
//  6. Send 0x48 then data 0x1F, read cg_rd_addr 8 -> 0x1F with LCD1602_CGRAM_EN, 0x00 without.

Source files
------------

// File: rtl/lcd1602_bus_responder_if.sv
// LCD1602 8-bit write bus: the panel controller drives it (master) and the responder samples it (slave).
// The signals are plain wires with no handshake; a transaction is taken on the falling edge of lcd_enable.
interface lcd1602_bus_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_enable;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_enable, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_enable, input  lcd_data);
endinterface

// File: rtl/lcd1602_bus_responder.sv
// LCD1602 bus responder: executes HD44780-style writes into a 32-char shadow DDRAM. Effect lands 2 cycles after the enable fall.
// busy covers execution; a fall while busy, or a read (rw=1), is dropped with a bad_access pulse. LCD1602_CGRAM_EN adds a 64x5 CGRAM.
module lcd1602_bus_responder #(
  parameter int CMD_CYCLES   = 4,
  parameter int CLEAR_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  lcd1602_bus_responder_if.slave        lcd,
  input  logic [4:0]                    rd_addr,
  output logic [7:0]                    rd_char,
  input  logic [5:0]                    cg_rd_addr,
  output logic [4:0]                    cg_rd_data,
  output logic [6:0]                    cursor_addr,
  output logic                          display_on,
  output logic                          cursor_on,
  output logic                          blink_on,
  output logic                          two_line,
  output logic                          busy,
  output logic                          cmd_strobe,
  output logic                          bad_access
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FILL, S_HOLD} state_t;

  localparam logic [15:0] CMD_LOAD   = 16'(CMD_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  state_t      state;
  logic        en_q, rs_q, rw_q;
  logic [7:0]  data_q;
  logic        cap_rs;
  logic [7:0]  cap_data;
  logic        id;
  logic        cg_mode;
  logic [5:0]  cg_addr;
  logic [4:0]  fill_idx;
  logic [15:0] cnt;
  logic [7:0]  ddram [32];
  logic        fall;
  logic        cg_we;

  assign fall  = en_q & ~lcd.lcd_enable;
  assign cg_we = !reset && (state == S_EXEC) && cap_rs && cg_mode;

  // Line 1 ends at 0x27 and line 2 at 0x67; the counter hops between them.
  function automatic logic [6:0] ddram_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FILL;
      fill_idx    <= '0;
      busy        <= 1'b1;
      cnt         <= '0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      cap_rs      <= 1'b0;
      cap_data    <= '0;
      cursor_addr <= '0;
      id          <= 1'b1;
      cg_mode     <= 1'b0;
      cg_addr     <= '0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      cmd_strobe  <= 1'b0;
      bad_access  <= 1'b0;
      rd_char     <= '0;
    end else begin
      en_q       <= lcd.lcd_enable;
      rs_q       <= lcd.lcd_rs;
      rw_q       <= lcd.lcd_rw;
      data_q     <= lcd.lcd_data;
      cmd_strobe <= 1'b0;
      bad_access <= fall && ((state != S_IDLE) || rw_q);
      rd_char    <= ddram[rd_addr];

      case (state)
        S_IDLE: begin
          if (fall && !rw_q) begin
            cap_rs   <= rs_q;
            cap_data <= data_q;
            busy     <= 1'b1;
            state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          state <= S_HOLD;
          cnt   <= CMD_LOAD;
          if (cap_rs) begin
            if (cg_mode) begin
              cg_addr <= id ? cg_addr + 6'd1 : cg_addr - 6'd1;
            end else begin
              if (cursor_addr[6:4] == 3'b000)
                ddram[{1'b0, cursor_addr[3:0]}] <= cap_data;
              else if (cursor_addr[6:4] == 3'b100)
                ddram[{1'b1, cursor_addr[3:0]}] <= cap_data;
              cursor_addr <= ddram_step(cursor_addr, id);
            end
          end else begin
            casez (cap_data)
              8'b1???????: begin cursor_addr <= cap_data[6:0]; cg_mode <= 1'b0; end
              8'b01??????: begin cg_addr <= cap_data[5:0]; cg_mode <= 1'b1; end
              8'b001?????: two_line <= cap_data[3];
              8'b0001????: if (!cap_data[3]) cursor_addr <= ddram_step(cursor_addr, cap_data[2]);
              8'b00001???: begin
                display_on <= cap_data[2];
                cursor_on  <= cap_data[1];
                blink_on   <= cap_data[0];
              end
              8'b000001??: id <= cap_data[1];
              8'b0000001?: begin cursor_addr <= '0; cg_mode <= 1'b0; end
              8'b00000001: begin
                cursor_addr <= '0;
                id          <= 1'b1;
                cg_mode     <= 1'b0;
                fill_idx    <= '0;
                state       <= S_FILL;
              end
              default: ;
            endcase
          end
        end

        S_FILL: begin
          ddram[fill_idx] <= 8'h20;
          fill_idx        <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) begin
            state <= S_HOLD;
            cnt   <= CLEAR_LOAD;
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            cmd_strobe <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LCD1602_CGRAM_EN
  // CGRAM has no reset so custom glyphs survive a panel reset.
  logic [4:0] cgram [64];

  always_ff @(posedge clk) begin
    if (cg_we) cgram[cg_addr] <= cap_data[4:0];
    if (reset) cg_rd_data <= '0;
    else       cg_rd_data <= cgram[cg_rd_addr];
  end
`else
  logic unused_cg;
  assign unused_cg = ^{cg_we, cg_rd_addr};

  always_ff @(posedge clk) begin
    cg_rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// Directed bench for lcd1602_bus_responder: one task per scenario with inline expected values.
module tb_lcd1602_bus_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [5:0] cg_rd_addr = '0;
  logic [4:0] cg_rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, two_line;
  logic       busy, cmd_strobe, bad_access;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int bad_cnt = 0;
  int busy_cnt = 0;

`ifdef LCD1602_CGRAM_EN
  localparam logic [4:0] CG_EXP = 5'h1F;
`else
  localparam logic [4:0] CG_EXP = 5'h00;
`endif

  always #5 clk = ~clk;

  lcd1602_bus_responder_if bus();

  lcd1602_bus_responder #(.CMD_CYCLES(4), .CLEAR_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .lcd(bus),
    .rd_addr(rd_addr), .rd_char(rd_char),
    .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .busy(busy),
    .cmd_strobe(cmd_strobe), .bad_access(bad_access)
  );

  always @(negedge clk) begin
    if (cmd_strobe) strobe_cnt++;
    if (bad_access) bad_cnt++;
    if (busy)       busy_cnt++;
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data = d; bus.lcd_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.lcd_enable = 1'b0;
  endtask

  // Bounded wait for the next cmd_strobe; a timeout is recorded as a failure.
  task automatic wait_done(input string name);
    int s0 = strobe_cnt;
    for (int i = 0; i < 300 && strobe_cnt == s0; i++) @(negedge clk);
    checks++;
    if (strobe_cnt == s0) begin
      failures++;
      $display("FAIL %s_done: cmd_strobe never seen within 300 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_char(input logic [4:0] a, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    int s0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, cursor_addr, display_on, cursor_on, blink_on, two_line, cmd_strobe, bad_access} !== {1'b1, 7'h00, 6'b0}) begin
      failures++;
      $display("FAIL reset_regs: busy=%b cursor=%h d/c/b/n=%b%b%b%b strobe=%b bad=%b, want busy=1 rest 0",
               busy, cursor_addr, display_on, cursor_on, blink_on, two_line, cmd_strobe, bad_access);
    end
    checks++;
    if (rd_char !== 8'h00 || cg_rd_data !== 5'h00) begin
      failures++;
      $display("FAIL reset_rd: rd_char=%h cg_rd_data=%h, want 00/00", rd_char, cg_rd_data);
    end
    s0 = strobe_cnt;
    @(posedge clk); #1 reset = 1'b0;
    repeat (32 + 64 + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || strobe_cnt != s0 + 1) begin
      failures++;
      $display("FAIL reset_fill_done: busy=%b strobes=%0d, want busy=0 strobes=1", busy, strobe_cnt - s0);
    end
    for (int i = 0; i < 32; i++) begin
      read_char(5'(i), v);
      checks++;
      if (v !== 8'h20) begin
        failures++;
        $display("FAIL reset_space[%0d]: got %h want 20", i, v);
      end
    end
    checks++;
    if (cursor_addr !== 7'h00) begin
      failures++;
      $display("FAIL reset_cursor: got %h want 00", cursor_addr);
    end
  endtask

  task automatic test_ddram_write;
    logic [7:0] v;
    int s0 = strobe_cnt;
    int b0 = busy_cnt;
    bus_write(1'b0, 8'h84); wait_done("set_addr");
    bus_write(1'b1, 8'h46); wait_done("write_f");
    read_char(5'd4, v);
    checks++;
    if (v !== 8'h46) begin failures++; $display("FAIL ddram_char4: got %h want 46", v); end
    checks++;
    if (cursor_addr !== 7'h05) begin failures++; $display("FAIL ddram_cursor: got %h want 05", cursor_addr); end
    checks++;
    if (strobe_cnt - s0 != 2) begin failures++; $display("FAIL ddram_strobes: got %0d want 2", strobe_cnt - s0); end
    checks++;
    if (busy_cnt - b0 != 10) begin failures++; $display("FAIL ddram_busy_cycles: got %0d want 10", busy_cnt - b0); end
  endtask

  task automatic test_display_function;
    bus_write(1'b0, 8'h0C); wait_done("disp_ctrl");
    bus_write(1'b0, 8'h38); wait_done("func_set");
    checks++;
    if ({display_on, cursor_on, blink_on} !== 3'b100) begin
      failures++;
      $display("FAIL display_dcb: got %b%b%b want 100", display_on, cursor_on, blink_on);
    end
    checks++;
    if (two_line !== 1'b1) begin failures++; $display("FAIL two_line: got %b want 1", two_line); end
  endtask

  task automatic test_decrement_wrap;
    logic [7:0] v;
    bus_write(1'b0, 8'h04); wait_done("entry_dec");
    bus_write(1'b0, 8'hC0); wait_done("addr_40");
    bus_write(1'b1, 8'h41); wait_done("write_a");
    read_char(5'd16, v);
    checks++;
    if (v !== 8'h41) begin failures++; $display("FAIL dec_char16: got %h want 41", v); end
    checks++;
    if (cursor_addr !== 7'h27) begin failures++; $display("FAIL dec_cursor: got %h want 27", cursor_addr); end
  endtask

  task automatic test_step_wrap;
    logic [7:0] v;
    bus_write(1'b0, 8'h06); wait_done("entry_inc");
    bus_write(1'b0, 8'hA7); wait_done("addr_27");
    bus_write(1'b1, 8'h5A); wait_done("write_27");
    checks++;
    if (cursor_addr !== 7'h40) begin failures++; $display("FAIL inc_27_to_40: got %h want 40", cursor_addr); end
    read_char(5'd16, v);
    checks++;
    if (v !== 8'h41) begin failures++; $display("FAIL unmapped_write: char16 got %h want 41", v); end
    bus_write(1'b0, 8'hE7); wait_done("addr_67");
    bus_write(1'b1, 8'h5A); wait_done("write_67");
    checks++;
    if (cursor_addr !== 7'h00) begin failures++; $display("FAIL inc_67_to_00: got %h want 00", cursor_addr); end
    bus_write(1'b0, 8'h10); wait_done("shift_left");
    checks++;
    if (cursor_addr !== 7'h67) begin failures++; $display("FAIL left_00_to_67: got %h want 67", cursor_addr); end
    bus_write(1'b0, 8'h14); wait_done("shift_right");
    checks++;
    if (cursor_addr !== 7'h00) begin failures++; $display("FAIL right_67_to_00: got %h want 00", cursor_addr); end
    bus_write(1'b0, 8'h1C); wait_done("display_shift");
    checks++;
    if (cursor_addr !== 7'h00) begin failures++; $display("FAIL shift_s1_noop: got %h want 00", cursor_addr); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    int bd0 = bad_cnt;
    int s0 = strobe_cnt;
    @(posedge clk); #1;
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h85; bus.lcd_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.lcd_enable = 1'b0;
    @(posedge clk); #1;
    bus.lcd_rs = 1'b1; bus.lcd_data = 8'h58; bus.lcd_enable = 1'b1;
    @(posedge clk); #1 bus.lcd_enable = 1'b0;
    wait_done("overlap");
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bad_cnt - bd0 != 1) begin failures++; $display("FAIL overlap_bad: got %0d want 1", bad_cnt - bd0); end
    checks++;
    if (strobe_cnt - s0 != 1) begin failures++; $display("FAIL overlap_strobes: got %0d want 1", strobe_cnt - s0); end
    checks++;
    if (cursor_addr !== 7'h05) begin failures++; $display("FAIL overlap_cursor: got %h want 05", cursor_addr); end
    read_char(5'd5, v);
    checks++;
    if (v !== 8'h20) begin failures++; $display("FAIL overlap_char5: got %h want 20", v); end
  endtask

  task automatic test_read_drop;
    logic [7:0] v;
    int bd0 = bad_cnt;
    int b0 = busy_cnt;
    @(posedge clk); #1;
    bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b1; bus.lcd_data = 8'h58; bus.lcd_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.lcd_enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.lcd_rw = 1'b0;
    checks++;
    if (bad_cnt - bd0 != 1 || busy_cnt != b0) begin
      failures++;
      $display("FAIL read_drop: bad=%0d busy_cycles=%0d, want 1 and 0", bad_cnt - bd0, busy_cnt - b0);
    end
    read_char(5'd5, v);
    checks++;
    if (v !== 8'h20 || cursor_addr !== 7'h05) begin
      failures++;
      $display("FAIL read_drop_state: char5=%h cursor=%h, want 20/05", v, cursor_addr);
    end
  endtask

  task automatic test_cgram;
    bus_write(1'b0, 8'h48); wait_done("cg_addr");
    bus_write(1'b1, 8'h1F); wait_done("cg_write");
    @(posedge clk); #1 cg_rd_addr = 6'd8;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cg_rd_data !== CG_EXP) begin failures++; $display("FAIL cgram_row8: got %h want %h", cg_rd_data, CG_EXP); end
    checks++;
    if (cursor_addr !== 7'h05) begin failures++; $display("FAIL cgram_cursor: got %h want 05", cursor_addr); end
  endtask

  task automatic test_clear;
    logic [7:0] v;
    int b0;
    bus_write(1'b0, 8'h04); wait_done("entry_dec2");
    b0 = busy_cnt;
    bus_write(1'b0, 8'h01); wait_done("clear");
    checks++;
    if (busy_cnt - b0 != 97) begin failures++; $display("FAIL clear_busy_cycles: got %0d want 97", busy_cnt - b0); end
    read_char(5'd4, v);
    checks++;
    if (v !== 8'h20 || cursor_addr !== 7'h00) begin
      failures++;
      $display("FAIL clear_state: char4=%h cursor=%h, want 20/00", v, cursor_addr);
    end
    bus_write(1'b1, 8'h31); wait_done("post_clear_write");
    read_char(5'd0, v);
    checks++;
    if (v !== 8'h31 || cursor_addr !== 7'h01) begin
      failures++;
      $display("FAIL clear_id_ddram: char0=%h cursor=%h, want 31/01", v, cursor_addr);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    bus_write(1'b1, 8'h33);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (32 + 64 + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cursor_addr !== 7'h00 || display_on !== 1'b0 || two_line !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_regs: busy=%b cursor=%h disp=%b two_line=%b, want 0/00/0/0",
               busy, cursor_addr, display_on, two_line);
    end
    read_char(5'd0, v);
    checks++;
    if (v !== 8'h20) begin failures++; $display("FAIL reset_mid_char0: got %h want 20", v); end
    @(posedge clk); #1 cg_rd_addr = 6'd8;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cg_rd_data !== CG_EXP) begin failures++; $display("FAIL reset_keeps_cgram: got %h want %h", cg_rd_data, CG_EXP); end
  endtask

  initial begin
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_enable = 1'b0; bus.lcd_data = 8'h00;
    test_reset();
    test_ddram_write();
    test_display_function();
    test_decrement_wrap();
    test_step_wrap();
    test_back_to_back();
    test_read_drop();
    test_cgram();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
